// File: rtl/jtag_scan_host_if.sv
// rtl/jtag_scan_host_if.sv - command, load-word and capture-word streams of the scan host
// The master side belongs to the debug/boot agent, the slave side to jtag_scan_host.
interface jtag_scan_host_if #(
   parameter int WIDTH = 32
);
   logic             cmd_valid;
   logic [1:0]       cmd_op;
   logic             cmd_ready;
   logic             wr_valid;
   logic [WIDTH-1:0] wr_data;
   logic             wr_ready;
   logic             rd_valid;
   logic [WIDTH-1:0] rd_data;
   logic             rd_ready;

   modport master (
      output cmd_valid, cmd_op, wr_valid, wr_data, rd_ready,
      input  cmd_ready, wr_ready, rd_valid, rd_data
   );

   modport slave (
      input  cmd_valid, cmd_op, wr_valid, wr_data, rd_ready,
      output cmd_ready, wr_ready, rd_valid, rd_data
   );
endinterface

// File: rtl/jtag_scan_host.sv
// rtl/jtag_scan_host.sv - host controller driving the word-serial scan chain of jtag_ram8
// Performs LOAD, DUMP (recirculating rotation) and EXCHANGE of DEPTH words per command.
module jtag_scan_host #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   jtag_scan_host_if.slave  bus,
   output logic             Jen,
   output logic [WIDTH-1:0] Jin,
   input  logic [WIDTH-1:0] Jout,
   output logic             busy,
   output logic             done
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_DUMP = 2'b01;
   localparam logic [1:0] OP_EXCH = 2'b10;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [CW-1:0]    count_q, count_d;
   logic             rd_valid_q, rd_valid_d;
   logic [WIDTH-1:0] rd_data_q, rd_data_d;

   logic uses_input, uses_output, out_ok, wr_ok, shift;

   // Reserved opcode is folded into DUMP at accept time, so op_q only ever holds 00/01/10.
   assign uses_input  = (op_q == OP_LOAD) || (op_q == OP_EXCH);
   assign uses_output = (op_q != OP_LOAD);
   assign out_ok      = !rd_valid_q || bus.rd_ready;
   assign wr_ok       = (state_q == S_RUN) && uses_input && (!uses_output || out_ok);
   assign shift       = (state_q == S_RUN) && (uses_input ? (bus.wr_valid && wr_ok) : out_ok);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         op_q       <= OP_LOAD;
         count_q    <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         count_q    <= count_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      count_d    = count_q;
      rd_valid_d = rd_valid_q;
      rd_data_d  = rd_data_q;
      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               state_d = S_RUN;
               op_d    = (bus.cmd_op == 2'b11) ? OP_DUMP : bus.cmd_op;
               count_d = '0;
            end
         end
         S_RUN: begin
            if (shift) begin
               count_d = count_q + 1'b1;
               if (count_q == CW'(DEPTH - 1)) state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // A fresh capture takes priority over the drain of the previous word in the same cycle.
      if (rd_valid_q && bus.rd_ready) rd_valid_d = 1'b0;
      if (shift && uses_output) begin
         rd_valid_d = 1'b1;
         rd_data_d  = Jout;
      end
   end

   always_comb begin
      bus.cmd_ready = (state_q == S_IDLE);
      bus.wr_ready  = wr_ok;
      bus.rd_valid  = rd_valid_q;
      bus.rd_data   = rd_data_q;
      Jen           = shift;
      Jin           = (op_q == OP_DUMP) ? Jout : bus.wr_data;
      busy          = (state_q != S_IDLE);
      done          = (state_q == S_DONE);
   end
endmodule

// File: tb/tb_jtag_scan_host.sv
// tb/tb_jtag_scan_host.sv - scoreboard bench for jtag_scan_host with a behavioural 8-word scan chain
module tb_jtag_scan_host;
   logic        clk = 1'b0;
   logic        reset;
   logic        Jen;
   logic [31:0] Jin;
   logic [31:0] Jout;
   logic        busy;
   logic        done;

   jtag_scan_host_if #(.WIDTH(32)) bus ();

   jtag_scan_host #(.WIDTH(32), .DEPTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .Jen   (Jen),
      .Jin   (Jin),
      .Jout  (Jout),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   logic [31:0] chain [8];
   assign Jout = chain[7];
   always @(posedge clk) begin
      if (Jen) begin
         for (int i = 7; i > 0; i--) chain[i] <= chain[i-1];
         chain[0] <= Jin;
      end
   end

   int n_cmp = 0;
   int n_fail = 0;
   logic [31:0] exp_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.rd_valid && bus.rd_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rd_unexpected: got 0x%0h, expected no word", bus.rd_data);
         end else begin
            check("rd_data", bus.rd_data, exp_q.pop_front());
         end
      end
   end

   logic [31:0] wa [8];
   logic [31:0] ra [8];
   logic [31:0] ex [8];
   int run_cycles, shifts, stall_shifts, jen_bad, busy_bad;

   task automatic check_ram();
      for (int k = 0; k < 8; k++) check($sformatf("ram_addr%0d", k), chain[k], ex[k]);
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
      check({tag, "_jen"},       32'(Jen),           32'd0);
      check({tag, "_rd_valid"},  32'(bus.rd_valid),  32'd0);
      check({tag, "_wr_ready"},  32'(bus.wr_ready),  32'd0);
      check({tag, "_busy"},      32'(busy),          32'd0);
      check({tag, "_done"},      32'(done),          32'd0);
   endtask

   task automatic do_cmd(input logic [1:0] op, input bit has_rd, input bit toggle_wr,
                         input int rd_stall, input int abort_at);
      bit uses_in, dump_mode, seen_done;
      int widx, cyc, stall_left;
      uses_in   = (op == 2'b00) || (op == 2'b10);
      dump_mode = (op == 2'b01) || (op == 2'b11);
      if (has_rd) for (int i = 0; i < 8; i++) exp_q.push_back(ra[i]);
      @(posedge clk); #1;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      widx = 0; cyc = 0; stall_left = rd_stall; seen_done = 0;
      run_cycles = 0; shifts = 0; stall_shifts = 0; jen_bad = 0; busy_bad = 0;
      while (!seen_done && cyc < 200) begin
         bus.wr_valid = uses_in && (widx < 8) && (!toggle_wr || (cyc % 2 == 1));
         bus.wr_data  = (widx < 8) ? wa[widx] : 32'h0;
         if (bus.rd_valid && stall_left > 0) begin
            bus.rd_ready = 1'b0;
            stall_left--;
         end else begin
            bus.rd_ready = 1'b1;
         end
         @(negedge clk);
         if (done) seen_done = 1;
         else if (busy) run_cycles++;
         if (busy && bus.cmd_ready) busy_bad++;
         if (Jen) begin
            shifts++;
            if (uses_in) widx++;
            if (uses_in && !bus.wr_valid) jen_bad++;
            if (!bus.rd_ready && bus.rd_valid) stall_shifts++;
            if (dump_mode) check("jin_eq_jout", Jin, Jout);
         end
         if (abort_at >= 0 && shifts == abort_at) break;
         @(posedge clk); #1;
         cyc++;
      end
      check("cmd_ready_low_while_busy", busy_bad, 0);
      if (abort_at < 0) begin
         bus.wr_valid = 1'b0;
         check("done_seen", 32'(seen_done), 32'd1);
         @(posedge clk); #1;
         bus.rd_ready = 1'b1;
         @(negedge clk);
         check("done_one_cycle", 32'(done), 32'd0);
         check("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      reset         = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
      bus.wr_valid  = 1'b0;
      bus.wr_data   = 32'h0;
      bus.rd_ready  = 1'b1;
      for (int k = 0; k < 8; k++) chain[k] = 32'h0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      reset_checks("por");

      // LOAD 0x70..0x00 back to back
      for (int k = 0; k < 8; k++) begin wa[k] = 32'h70 - 32'h10 * k; ex[k] = 32'h10 * k; end
      do_cmd(2'b00, 0, 0, 0, -1);
      check("load_run_cycles", run_cycles, 8);
      check("load_shifts", shifts, 8);
      check_ram();

      // DUMP, free-running consumer
      for (int k = 0; k < 8; k++) ra[k] = 32'h70 - 32'h10 * k;
      do_cmd(2'b01, 1, 0, 0, -1);
      check("dump_shifts", shifts, 8);
      check_ram();

      // EXCHANGE 0xA0..0xA7 capturing the loaded image
      for (int k = 0; k < 8; k++) begin wa[k] = 32'hA0 + k; ex[k] = 32'hA7 - k; end
      do_cmd(2'b10, 1, 0, 0, -1);
      check("exch_run_cycles", run_cycles, 8);
      check_ram();

      // DUMP with a 5-cycle consumer stall after the first capture
      for (int k = 0; k < 8; k++) ra[k] = 32'hA0 + k;
      do_cmd(2'b01, 1, 0, 5, -1);
      check("stall_shifts", stall_shifts, 0);
      check("stall_run_cycles", run_cycles, 13);
      check_ram();

      // LOAD with wr_valid toggling
      for (int k = 0; k < 8; k++) begin wa[k] = 32'hB0 + k; ex[k] = 32'hB7 - k; end
      do_cmd(2'b00, 0, 1, 0, -1);
      check("toggle_run_cycles", run_cycles, 16);
      check("toggle_shifts", shifts, 8);
      check("toggle_jen_without_wr_valid", jen_bad, 0);
      check_ram();

      // LOAD aborted by reset after 3 shifts, then a full LOAD
      for (int k = 0; k < 8; k++) begin wa[k] = 32'h70 - 32'h10 * k; ex[k] = 32'h10 * k; end
      do_cmd(2'b00, 0, 0, 0, 3);
      @(posedge clk); #1;
      reset = 1'b1;
      bus.wr_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      reset_checks("abort");
      do_cmd(2'b00, 0, 0, 0, -1);
      check("reload_shifts", shifts, 8);
      check_ram();

      // Reserved opcode behaves as DUMP
      for (int k = 0; k < 8; k++) ra[k] = 32'h70 - 32'h10 * k;
      do_cmd(2'b11, 1, 0, 0, -1);
      check_ram();

      repeat (3) @(posedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/jtag_scan_host.md
Name: jtag_scan_host

Overview:
- Host-side controller that drives the word-serial scan chain of jtag_ram8 through its Jen/Jin/Jout ports.
- Bulk-loads an 8-word image into the chain, dumps the chain non-destructively by recirculating Jout into Jin, or exchanges (loads new words while capturing old ones).
- Sits between a debug/boot agent (valid/ready streams) and the RAM's scan port; the RAM's Addr/Din/Wen side is untouched.

Parameters:
- WIDTH, 32, scan word width; matches RAM word width.
- DEPTH, 8, number of registers in the chain (shifts per command).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_op  in  2  00=LOAD, 01=DUMP, 10=EXCHANGE, 11=reserved (accepted, treated as DUMP).
- cmd_ready  out  1  high when IDLE; command accepted on cmd_valid&&cmd_ready.
- wr_valid  in  1  load word available.
- wr_data  in  WIDTH  load word.
- wr_ready  out  1  load word consumed on wr_valid&&wr_ready.
- rd_valid  out  1  captured word available.
- rd_data  out  WIDTH  captured word.
- rd_ready  in  1  consumer accepts on rd_valid&&rd_ready.
- Jen  out  1  chain shift enable, to RAM Jen.
- Jin  out  WIDTH  chain input, to RAM Jin.
- Jout  in  WIDTH  chain output, from RAM Jout (= last register).
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse after the final shift.

Behaviour:
- Chain model: on each edge with Jen=1, reg0<=Jin, reg[i]<=reg[i-1], Jout=reg[DEPTH-1].
- States: IDLE, RUN, DONE. IDLE->RUN on command accept (op latched, count<=0). RUN->DONE on the shift where count==DEPTH-1. DONE->IDLE unconditionally next cycle. done=1 exactly in the DONE cycle. busy=(state!=IDLE).
- Uses input: LOAD, EXCHANGE. Uses output: DUMP, EXCHANGE.
- out_ok = !rd_valid || rd_ready.
- wr_ready = RUN && uses_input && (uses_output ? out_ok : 1).
- shift (=Jen) = RUN && (uses_input ? wr_valid && wr_ready : out_ok). Combinational, zero latency.
- Jin = (op==DUMP) ? Jout : wr_data. When Jen=0, Jin is don't-care; the bench checks Jin only when Jen=1.
- Capture: on a shift with uses_output, rd_data<=Jout (pre-shift value) and rd_valid<=1. Otherwise rd_valid clears on rd_ready.
- Ordering:
  - Dump/exchange words emerge in address order DEPTH-1 down to 0.
  - Load words land so the first word supplied ends in address DEPTH-1 and the last in address 0.
  - Dump is a full rotation, so RAM contents are unchanged after DUMP.
- count increments by 1 per shift, width clog2(DEPTH)+1; no wrap inside a command.
- Stalls: any number of idle cycles between shifts is legal; Jen stays 0 during stalls and the chain holds.
- DONE asserts after the last shift even if the last captured word is still pending in rd_data. A new command may start while rd_valid=1; its first capture waits for out_ok.
- cmd_valid while busy is ignored (cmd_ready=0).
- Reset (any state, including mid-command):
  - state=IDLE, count=0, rd_valid=0, rd_data=0, done=0.
  - Jen=0, wr_ready=0, busy=0, cmd_ready=1 from the first cycle after reset.
  - Chain contents are left partially shifted and are not restored.
- EXCHANGE back-pressure: a shift needs wr_valid and out_ok in the same cycle. wr_ready is low while the out slot is full and not being drained.

Test Plan:
- LOAD words 0x70,0x60,...,0x00 with wr_valid held high -> Jen high for exactly 8 consecutive cycles, done pulses one cycle later, RAM Addr k reads 0x10*k.
- DUMP after the previous test with rd_ready=1 -> rd_data sequence 0x70,0x60,...,0x00. RAM read-back at each Addr still 0x10*k. Jin equals Jout on every shift.
- EXCHANGE with words 0xA0..0xA7 after the load -> captured 0x70..0x00. Afterwards RAM Addr 7 = 0xA0, Addr 0 = 0xA7.
- DUMP with rd_ready held low for 5 cycles after the first capture -> Jen=0 and chain frozen during the stall. Data order is intact and no word is lost or duplicated.
- LOAD with wr_valid toggling every other cycle -> exactly 8 shifts in 16 cycles; Jen never high while wr_valid=0.
- reset asserted after 3 shifts of a LOAD -> next cycle cmd_ready=1, Jen=0, rd_valid=0. A following full LOAD succeeds with correct contents.
